// File: rtl/match_engine_if.sv
// Ball/score/LED signal bundle of the match engine.
// The engine takes the slave view and the field/host side takes the master view.
interface match_engine_if #(
  parameter int COORD_W = 10,
  parameter int SCORE_W = 8
);
  logic               start;
  logic               pause;
  logic [COORD_W-1:0] BallX;
  logic [COORD_W-1:0] BallY;
  logic [SCORE_W-1:0] score1;
  logic [SCORE_W-1:0] score2;
  logic               resetfieldsig;
  logic               goal_pulse;
  logic [1:0]         winner;
  logic               game_over;
  logic [7:0]         greenLeds;
  logic [17:0]        redLeds;

  modport master (
    output start, pause, BallX, BallY,
    input  score1, score2, resetfieldsig, goal_pulse, winner, game_over,
           greenLeds, redLeds
  );

  modport slave (
    input  start, pause, BallX, BallY,
    output score1, score2, resetfieldsig, goal_pulse, winner, game_over,
           greenLeds, redLeds
  );
endinterface

// File: rtl/match_engine.sv
// Goal detection, scoring and match control for the two-player soccer field.
// Define SCORE_BCD_EN for packed two-digit BCD scores (SCORE_W must then be 8).
module match_engine #(
  parameter int COORD_W          = 10,
  parameter int SCORE_W          = 8,
  parameter int WIN_SCORE        = 10,
  parameter int GOAL_Y_MIN       = 209,
  parameter int GOAL_Y_MAX       = 271,
  parameter int LEFT_GOAL_X_MAX  = 30,
  parameter int RIGHT_GOAL_X_MIN = 609,
  parameter int FIELD_X_MAX      = 639,
  parameter int GOAL_CONFIRM     = 2,
  parameter int RESET_HOLD       = 4,
  parameter int BLINK_W          = 26
) (
  input  logic          Clk,
  input  logic          Reset,
  match_engine_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_KICKOFF,
    S_PLAY,
    S_GOAL_HOLD,
    S_AWARD,
    S_RESUME,
    S_GAME_OVER
  } state_e;

  typedef enum logic [1:0] {REG_NONE, REG_LEFT, REG_RIGHT} region_e;

  typedef enum logic [1:0] {
    WIN_NONE = 2'b00,
    WIN_P1   = 2'b01,
    WIN_P2   = 2'b10
  } winner_e;

  localparam logic [COORD_W-1:0] Y_MIN     = COORD_W'(GOAL_Y_MIN);
  localparam logic [COORD_W-1:0] Y_MAX     = COORD_W'(GOAL_Y_MAX);
  localparam logic [COORD_W-1:0] LX_MAX    = COORD_W'(LEFT_GOAL_X_MAX);
  localparam logic [COORD_W-1:0] RX_MIN    = COORD_W'(RIGHT_GOAL_X_MIN);
  localparam logic [COORD_W-1:0] FX_MAX    = COORD_W'(FIELD_X_MAX);
  localparam logic [3:0]         CONFIRM   = 4'(GOAL_CONFIRM);
  localparam logic [7:0]         HOLD_LAST = 8'(RESET_HOLD - 1);

`ifdef SCORE_BCD_EN
  if (SCORE_W != 8) begin : g_bcd_width_check
    $error("match_engine: SCORE_BCD_EN requires SCORE_W == 8");
  end
  localparam bit                 WIN_OK   = (WIN_SCORE >= 1) && (WIN_SCORE <= 99);
  localparam logic [SCORE_W-1:0] WIN_CODE = SCORE_W'({4'(WIN_SCORE / 10), 4'(WIN_SCORE % 10)});
`else
  localparam bit                 WIN_OK   = (WIN_SCORE >= 1) && ((WIN_SCORE >> SCORE_W) == 0);
  localparam logic [SCORE_W-1:0] WIN_CODE = SCORE_W'(WIN_SCORE);
`endif

  // Saturating increment: never wraps past the largest representable score.
  function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] s);
`ifdef SCORE_BCD_EN
    if (s == 8'h99)       return s;
    if (s[3:0] == 4'd9)   return {s[7:4] + 4'd1, 4'd0};
    return {s[7:4], s[3:0] + 4'd1};
`else
    if (&s) return s;
    return s + SCORE_W'(1);
`endif
  endfunction

  state_e               state_q, state_d;
  region_e              region_q, region_d;
  winner_e              winner_q, winner_d;
  logic [SCORE_W-1:0]   score1_q, score1_d;
  logic [SCORE_W-1:0]   score2_q, score2_d;
  logic [3:0]           cnt_q, cnt_d;
  logic [7:0]           hold_q, hold_d;
  logic [BLINK_W-1:0]   blink_q, blink_d;
  logic                 goal_pulse_q, goal_pulse_d;
  logic                 led_on_q, led_on_d;

  logic                 y_in_mouth, in_left, in_right;
  region_e              region_now;
  logic [3:0]           cnt_inc;
  logic [SCORE_W-1:0]   award_score;

  assign y_in_mouth = (bus.BallY >= Y_MIN) && (bus.BallY <= Y_MAX);
  assign in_left    = y_in_mouth && (bus.BallX <= LX_MAX);
  assign in_right   = y_in_mouth && (bus.BallX >= RX_MIN) && (bus.BallX <= FX_MAX);
  assign region_now = in_left ? REG_LEFT : (in_right ? REG_RIGHT : REG_NONE);

  // A region change restarts the run with this cycle as its first in-region cycle.
  assign cnt_inc     = (region_now == region_q) ? cnt_q + 4'd1 : 4'd1;
  // During GOAL_HOLD/AWARD region_q remembers where the ball went in: left goal scores for player 2.
  assign award_score = sat_inc((region_q == REG_LEFT) ? score2_q : score1_q);

  // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d      = state_q;
    region_d     = region_q;
    winner_d     = winner_q;
    score1_d     = score1_q;
    score2_d     = score2_q;
    cnt_d        = cnt_q;
    hold_d       = hold_q;
    goal_pulse_d = 1'b0;
    blink_d      = blink_q + BLINK_W'(1);

    unique case (state_q)
      S_IDLE: begin
        if (bus.start) state_d = S_KICKOFF;
      end

      S_KICKOFF: begin
        score1_d = '0;
        score2_d = '0;
        winner_d = WIN_NONE;
        cnt_d    = '0;
        region_d = REG_NONE;
        state_d  = S_PLAY;
      end

      S_PLAY: begin
        if (!bus.pause) begin
          if (region_now == REG_NONE) begin
            cnt_d    = '0;
            region_d = REG_NONE;
          end else begin
            region_d = region_now;
            if (cnt_inc >= CONFIRM) begin
              cnt_d   = '0;
              hold_d  = '0;
              state_d = S_GOAL_HOLD;
            end else begin
              cnt_d = cnt_inc;
            end
          end
        end
      end

      S_GOAL_HOLD: begin
        if (hold_q == HOLD_LAST) state_d = S_AWARD;
        else                     hold_d  = hold_q + 8'd1;
      end

      S_AWARD: begin
        goal_pulse_d = 1'b1;
        if (region_q == REG_LEFT) score2_d = award_score;
        else                      score1_d = award_score;
        if (WIN_OK && (award_score == WIN_CODE)) begin
          winner_d = (region_q == REG_LEFT) ? WIN_P2 : WIN_P1;
          state_d  = S_GAME_OVER;
        end else begin
          state_d = S_RESUME;
        end
      end

      // Play restarts only once the ball is clear of both goal mouths.
      S_RESUME: begin
        if (!in_left && !in_right) begin
          cnt_d    = '0;
          region_d = REG_NONE;
          state_d  = S_PLAY;
        end
      end

      S_GAME_OVER: begin
        if (bus.start) state_d = S_KICKOFF;
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign led_on_d = (state_d == S_GAME_OVER) && !blink_d[BLINK_W-1];

  // NOTE: state updates use non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q      <= S_IDLE;
      region_q     <= REG_NONE;
      winner_q     <= WIN_NONE;
      score1_q     <= '0;
      score2_q     <= '0;
      cnt_q        <= '0;
      hold_q       <= '0;
      blink_q      <= '0;
      goal_pulse_q <= 1'b0;
      led_on_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      region_q     <= region_d;
      winner_q     <= winner_d;
      score1_q     <= score1_d;
      score2_q     <= score2_d;
      cnt_q        <= cnt_d;
      hold_q       <= hold_d;
      blink_q      <= blink_d;
      goal_pulse_q <= goal_pulse_d;
      led_on_q     <= led_on_d;
    end
  end

  assign bus.score1        = score1_q;
  assign bus.score2        = score2_q;
  assign bus.winner        = winner_q;
  assign bus.goal_pulse    = goal_pulse_q;
  assign bus.resetfieldsig = (state_q == S_KICKOFF) || (state_q == S_GOAL_HOLD);
  assign bus.game_over     = (state_q == S_GAME_OVER);
  assign bus.greenLeds     = {8{led_on_q}};
  assign bus.redLeds       = {18{led_on_q}};

endmodule

// File: tb/tb_match_engine.sv
// Directed bench for match_engine: a per-cycle vector table for goal detection,
// then hand sequences for win/LED blink, async reset mid-goal and the 9->10 score step.
module tb_match_engine;

  logic Clk;
  logic Reset;

  match_engine_if #(.COORD_W(10), .SCORE_W(8)) bus ();
  match_engine_if #(.COORD_W(10), .SCORE_W(8)) bus10 ();

  // Second instance sees identical stimulus; it only differs in the target score.
  assign bus10.start = bus.start;
  assign bus10.pause = bus.pause;
  assign bus10.BallX = bus.BallX;
  assign bus10.BallY = bus.BallY;

  match_engine #(.WIN_SCORE(3), .BLINK_W(4)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  match_engine #(.WIN_SCORE(10), .BLINK_W(4)) dut10 (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus10)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Reference blink counter: counts every clock since reset, same as the spec'd free-running counter.
  logic [3:0] blink_m;
  always @(posedge Clk or posedge Reset) begin
    if (Reset) blink_m <= '0;
    else       blink_m <= blink_m + 4'd1;
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic drive(input int x, input int y);
    bus.BallX = 10'(x);
    bus.BallY = 10'(y);
  endtask

  // From PLAY/RESUME: one centre cycle, ball in (x,y) for 2 cycles, then centre until the
  // cycle right after AWARD, where the new score and goal_pulse are visible.
  task automatic goal_seq(input int x, input int y);
    drive(320, 240); tick();
    drive(x, y);     repeat (2) tick();
    drive(320, 240); repeat (5) tick();
  endtask

  typedef struct {
    int start, pause, x, y, reps;
    int rf, gp, s1, s2;
  } vec_t;

  vec_t vq[$];

  task automatic add(input int st, input int pa, input int x, input int y, input int reps,
                     input int rf, input int gp, input int s1, input int s2);
    vec_t v;
    v = '{st, pa, x, y, reps, rf, gp, s1, s2};
    vq.push_back(v);
  endtask

  function automatic int to_code(input int n);
`ifdef SCORE_BCD_EN
    return ((n / 10) << 4) | (n % 10);
`else
    return n;
`endif
  endfunction

  int led_exp;

  initial begin
    Reset     = 1'b1;
    bus.start = 1'b0;
    bus.pause = 1'b0;
    drive(320, 240);

    //  start pause   x    y  reps  rf gp s1 s2
    add(1, 0, 320, 240,  1,   1, 0, 0, 0);   // KICKOFF
    add(0, 0, 320, 240,  1,   0, 0, 0, 0);   // PLAY
    add(0, 0,  10, 240,  1,   0, 0, 0, 0);   // left, first cycle
    add(0, 0,  10, 240,  1,   1, 0, 0, 0);   // confirmed -> GOAL_HOLD
    add(0, 0, 320, 240,  3,   1, 0, 0, 0);   // hold cycles 2..4
    add(0, 0, 320, 240,  1,   0, 0, 0, 0);   // AWARD
    add(0, 0, 320, 240,  1,   0, 1, 0, 1);   // score2 visible with pulse
    add(0, 0, 320, 240,  1,   0, 0, 0, 1);   // back in PLAY
    add(0, 0, 620, 240,  1,   0, 0, 0, 1);   // single right cycle
    add(0, 0, 320, 240,  2,   0, 0, 0, 1);   // no goal
    add(0, 0, 620, 240,  1,   0, 0, 0, 1);   // right, counter 1
    add(0, 1, 620, 240, 20,   0, 0, 0, 1);   // paused: counter frozen
    add(0, 0, 620, 240,  1,   1, 0, 0, 1);   // released -> GOAL_HOLD
    add(0, 0, 320, 240,  3,   1, 0, 0, 1);
    add(0, 0, 320, 240,  1,   0, 0, 0, 1);   // AWARD
    add(0, 0, 320, 240,  1,   0, 1, 1, 1);
    add(0, 0, 320, 240,  1,   0, 0, 1, 1);
    add(0, 0,  10, 240,  1,   0, 0, 1, 1);   // left then right: region change restarts count
    add(0, 0, 620, 240,  1,   0, 0, 1, 1);
    add(0, 0, 320, 240,  1,   0, 0, 1, 1);
    add(0, 0,  10, 200,  2,   0, 0, 1, 1);   // just below goal mouth
    add(0, 0, 620, 272,  2,   0, 0, 1, 1);   // just above goal mouth
    add(1, 0, 320, 240,  1,   0, 0, 1, 1);   // start ignored in PLAY
    add(0, 0, 320, 240,  1,   0, 0, 1, 1);

    repeat (2) tick();
    Reset = 1'b0;

    check("rst_rf",    int'(bus.resetfieldsig), 0);
    check("rst_gp",    int'(bus.goal_pulse),    0);
    check("rst_s1",    int'(bus.score1),        0);
    check("rst_s2",    int'(bus.score2),        0);
    check("rst_win",   int'(bus.winner),        0);
    check("rst_go",    int'(bus.game_over),     0);
    check("rst_green", int'(bus.greenLeds),     0);
    check("rst_red",   int'(bus.redLeds),       0);

    foreach (vq[i]) begin
      for (int r = 0; r < vq[i].reps; r++) begin
        bus.start = vq[i].start[0];
        bus.pause = vq[i].pause[0];
        drive(vq[i].x, vq[i].y);
        tick();
        check($sformatf("v%0d_rf", i), int'(bus.resetfieldsig), vq[i].rf);
        check($sformatf("v%0d_gp", i), int'(bus.goal_pulse),    vq[i].gp);
        check($sformatf("v%0d_s1", i), int'(bus.score1),        to_code(vq[i].s1));
        check($sformatf("v%0d_s2", i), int'(bus.score2),        to_code(vq[i].s2));
      end
    end
    bus.start = 1'b0;
    bus.pause = 1'b0;

    // Async reset on the second GOAL_HOLD cycle with scores 1:1.
    drive(10, 240);  repeat (2) tick();
    check("hold1_rf", int'(bus.resetfieldsig), 1);
    drive(320, 240); tick();
    #2 Reset = 1'b1;
    #1;
    check("arst_rf",  int'(bus.resetfieldsig), 0);
    check("arst_s1",  int'(bus.score1),        0);
    check("arst_s2",  int'(bus.score2),        0);
    check("arst_gp",  int'(bus.goal_pulse),    0);
    check("arst_win", int'(bus.winner),        0);
    repeat (2) tick();
    Reset = 1'b0;
    repeat (10) tick();
    check("post_rst_s2", int'(bus.score2),        0);
    check("post_rst_gp", int'(bus.goal_pulse),    0);
    check("post_rst_rf", int'(bus.resetfieldsig), 0);

    // Three right-goal goals win the match for player 1 (target 3).
    bus.start = 1'b1; tick();
    bus.start = 1'b0; tick();
    for (int g = 1; g <= 3; g++) begin
      goal_seq(620, 240);
      check($sformatf("win_s1_%0d", g),  int'(bus.score1),    to_code(g));
      check($sformatf("win_gp_%0d", g),  int'(bus.goal_pulse), 1);
      check($sformatf("win_w_%0d", g),   int'(bus.winner),     (g == 3) ? 1 : 0);
      check($sformatf("win_go_%0d", g),  int'(bus.game_over),  (g == 3) ? 1 : 0);
    end
    for (int c = 0; c < 20; c++) begin
      tick();
      led_exp = blink_m[3] ? 0 : 1;
      check($sformatf("led_g_%0d", c), int'(bus.greenLeds), led_exp ? 8'hFF : 0);
      check($sformatf("led_r_%0d", c), int'(bus.redLeds),   led_exp ? 18'h3FFFF : 0);
    end
    goal_seq(620, 240);
    check("over_s1", int'(bus.score1),        to_code(3));
    check("over_gp", int'(bus.goal_pulse),    0);
    check("over_rf", int'(bus.resetfieldsig), 0);
    check("over_go", int'(bus.game_over),     1);
    bus.start = 1'b1; tick();
    bus.start = 1'b0; tick();
    check("restart_s1",  int'(bus.score1),    0);
    check("restart_win", int'(bus.winner),    0);
    check("restart_go",  int'(bus.game_over), 0);
    check("restart_led", int'(bus.greenLeds), 0);

    // Left-goal run to 10 on the target-10 instance; the target-3 instance ends at 3.
    Reset = 1'b1; tick();
    Reset = 1'b0;
    bus.start = 1'b1; tick();
    bus.start = 1'b0; tick();
    for (int g = 1; g <= 10; g++) begin
      goal_seq(10, 240);
      check($sformatf("t10_s2_%0d", g), int'(bus10.score2),     to_code(g));
      check($sformatf("t10_gp_%0d", g), int'(bus10.goal_pulse), 1);
      check($sformatf("t10_w_%0d", g),  int'(bus10.winner),     (g == 10) ? 2 : 0);
      check($sformatf("t10_go_%0d", g), int'(bus10.game_over),  (g == 10) ? 1 : 0);
      if (g == 3) check("t3_p2_win", int'(bus.winner), 2);
    end
    check("t3_s2_final", int'(bus.score2), to_code(3));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
